alu_md_unit: RTL
================

# alu_md_unit

Parametrised execution unit for the Tomasulo core: accepts one issued op per cycle from the ALU reservation station and broadcasts the result on the CDB with a registered output. Covers RV32I integer/branch/jump ops and RV32M multiply/divide. RV32I ops and `MUL*` take one cycle; `DIV*`/`REM*` run on an iterative divider. Sits between the RS select logic and the CDB arbiter, and honours ROB rollback.

## Interface

**Parameters**
- `XLEN`, 32: operand/result width; a power of two, at least 8.
- `ENTRY_W`, 4: ROB tag width.
- `OP_W`, 6: opcode width.

**Ports**
- `clk_in`  in  1  clock
- `rst_in`  in  1  reset; synchronous, active-high
- `rdy_in`  in  1  global enable; low freezes all state
- `flush`  in  1  ROB rollback; kills all in-flight work
- `issue_valid`  in  1  op presented
- `issue_ready`  out  1  unit can accept this cycle
- `issue_op`  in  OP_W  opcode (shared op package)
- `issue_vj`, `issue_vk`, `issue_imm`, `issue_pc`  in  XLEN each  operands
- `issue_entry`  in  ENTRY_W  ROB tag
- `out_valid`  out  1  CDB broadcast, one-cycle pulse
- `out_result`  out  XLEN  rd value, or the branch-taken flag
- `out_pc`  out  XLEN  next PC
- `out_entry`  out  ENTRY_W  ROB tag

## Operation

**States**
- IDLE
- DIV_BUSY

**IDLE**
- `issue_ready` = `rdy_in`.
- On handshake with a non-divide op: compute combinationally and register all outputs; `out_valid` is 1 the next cycle.
- Back-to-back issue is allowed in every cycle.

**Divide entry and special cases**
- On handshake with `DIV`, `DIVU`, `REM` or `REMU`, go to DIV_BUSY.
- Divisor = 0: quotient = all ones; remainder = dividend. No DIV_BUSY; 1-cycle latency.
- Signed `-2^(XLEN-1) / -1`: quotient = dividend; remainder = 0. 1-cycle latency.

**DIV_BUSY**
- `issue_ready` = 0.
- The divider runs XLEN restoring iterations on magnitudes; signs are fixed up at the end.
- On the last iteration, register the result, pulse `out_valid` and return to IDLE.

**Arithmetic rules**
- Shift amount = low log2(XLEN) bits. For `*I` shifts use `imm[log2(XLEN)-1:0]`; for R-type use `vk`.
- `SRA`/`SRAI` shift arithmetically.
- `SLT*` produce 0 or 1, zero-extended.
- `MUL` gives the low XLEN bits. `MULH`, `MULHSU` and `MULHU` give the high XLEN bits of the 2·XLEN product, signed×signed, signed×unsigned and unsigned×unsigned respectively.

**Branches and jumps**
- Branches: `out_result` = 1 if taken, else 0. `out_pc` = `pc+imm` if taken, else `pc+4`.
- `JAL`: `out_result` = `pc+4`; `out_pc` = `pc+imm`.
- `JALR`: `out_result` = `pc+4`; `out_pc` = `(vj+imm) & ~1`.
- All other ops: `out_pc` = `pc+4`.
- `LUI` → `imm`; `AUIPC` → `pc+imm`.

**Unknown opcodes**
- Broadcast `out_result` = 0 so the ROB is never starved.
- Simulation-only warning.

## Timing

- **Reset:** state = IDLE. `out_valid` = 0; `out_result`, `out_pc` and `out_entry` = 0. `issue_ready` = 0 during the reset cycle.
- **Latency, non-divide:** handshake at edge T; `out_valid` high in cycle T+1.
- **Latency, divide:** handshake at edge T; `out_valid` high in cycle T+XLEN+1. `issue_ready` reasserts in the same cycle, so the next op can handshake at that cycle's edge.
- **`out_valid`:** high for exactly one cycle per accepted op. There is no back-pressure from the CDB.
- **`flush`:** at the next edge, `out_valid` = 0 and state = IDLE. Any op handshaking in the flush cycle is dropped. Flush beats both reset-free completion and a concurrent issue.
- **`rdy_in` = 0:**
  - No state change: the divider counter holds.
  - `out_valid` is forced low but its pending pulse is retained and emitted once `rdy_in` returns.
  - Flush and reset still apply.
- **Reset mid-divide:** abandons the operation; no broadcast.

## Structure

**Shared op package** (existing op-code include)
- Gains codes for `MUL`, `MULH`, `MULHSU`, `MULHU`, `DIV`, `DIVU`, `REM`, `REMU`.
- Also holds the `is_div(op)` classification constant range.

**Sub-module `alu_div_iter`**
- Inputs: start, signed flag, rem flag, dividend, divisor.
- Outputs: done pulse, result.
- Has its own counter (`$clog2(XLEN)+1` bits) and an abort input driven by `flush`.
- Everything else lives in `alu_md_unit`.

## Test plan

- **Back-to-back issue:** reset, then `ADD 5+7`, `SRA 0x80000000>>>4`, `SLL 1<<33` on three consecutive cycles. Expect results 12, `0xF8000000`, 2 in cycles T+1..T+3, with tags preserved.
- **Branches and JALR:** `BLT vj=-1 vk=1 pc=0x100 imm=0x20` → result 1, `out_pc` 0x120. `BGEU` with the same operands → result 1, `out_pc` 0x120. `JALR vj=0x203 imm=0` → `out_pc` 0x202, result `pc+4`.
- **Signed divide:** `DIV -7/2` → −3 at T+33. `REM -7/2` → −1. `issue_ready` is low for cycles T+1..T+32, and a second op held valid is accepted at T+33.
- **Divide special cases:**
  - `DIVU x/0` → `0xFFFFFFFF` at T+1.
  - `REM 9/0` → 9.
  - `DIV 0x80000000/-1` → `0x80000000` at T+1.
  - `MULHU 0xFFFFFFFF²` → `0xFFFFFFFE`.
  - `MULH -1·-1` → 0.
- **Flush mid-divide:** at T+10, with a new `ADD` presented in the same cycle. Expect no broadcast for either, state IDLE at T+11, and the next `ADD` issued at T+11 broadcasts at T+12.
- **`rdy_in` low:** drop `rdy_in` for 5 cycles mid-divide. Completion moves from T+33 to T+38 with exactly one `out_valid` pulse. Reset asserted mid-divide → no broadcast; outputs 0.

Source files
------------

// File: rtl/alu_md_unit_pkg.sv
// ============================================================================
// Module      : alu_md_unit_pkg
// Description : Shared op-code table for the integer/mul/div execution unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_md_unit_pkg;

    localparam int c_OP_CODE_W = 6;

    typedef logic [c_OP_CODE_W-1:0] op_t;

    localparam op_t c_OP_ADD    = 6'd0;
    localparam op_t c_OP_SUB    = 6'd1;
    localparam op_t c_OP_SLL    = 6'd2;
    localparam op_t c_OP_SLT    = 6'd3;
    localparam op_t c_OP_SLTU   = 6'd4;
    localparam op_t c_OP_XOR    = 6'd5;
    localparam op_t c_OP_SRL    = 6'd6;
    localparam op_t c_OP_SRA    = 6'd7;
    localparam op_t c_OP_OR     = 6'd8;
    localparam op_t c_OP_AND    = 6'd9;
    localparam op_t c_OP_ADDI   = 6'd10;
    localparam op_t c_OP_SLTI   = 6'd11;
    localparam op_t c_OP_SLTIU  = 6'd12;
    localparam op_t c_OP_XORI   = 6'd13;
    localparam op_t c_OP_ORI    = 6'd14;
    localparam op_t c_OP_ANDI   = 6'd15;
    localparam op_t c_OP_SLLI   = 6'd16;
    localparam op_t c_OP_SRLI   = 6'd17;
    localparam op_t c_OP_SRAI   = 6'd18;
    localparam op_t c_OP_LUI    = 6'd19;
    localparam op_t c_OP_AUIPC  = 6'd20;
    localparam op_t c_OP_JAL    = 6'd21;
    localparam op_t c_OP_JALR   = 6'd22;
    localparam op_t c_OP_BEQ    = 6'd23;
    localparam op_t c_OP_BNE    = 6'd24;
    localparam op_t c_OP_BLT    = 6'd25;
    localparam op_t c_OP_BGE    = 6'd26;
    localparam op_t c_OP_BLTU   = 6'd27;
    localparam op_t c_OP_BGEU   = 6'd28;
    localparam op_t c_OP_MUL    = 6'd32;
    localparam op_t c_OP_MULH   = 6'd33;
    localparam op_t c_OP_MULHSU = 6'd34;
    localparam op_t c_OP_MULHU  = 6'd35;
    localparam op_t c_OP_DIV    = 6'd36;
    localparam op_t c_OP_DIVU   = 6'd37;
    localparam op_t c_OP_REM    = 6'd38;
    localparam op_t c_OP_REMU   = 6'd39;

    // Divide-class ops occupy one contiguous code range.
    localparam op_t c_OP_DIV_FIRST = c_OP_DIV;
    localparam op_t c_OP_DIV_LAST  = c_OP_REMU;

    function automatic logic is_div(input op_t op);
        return (op >= c_OP_DIV_FIRST) && (op <= c_OP_DIV_LAST);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_md_unit_div.sv
// ============================================================================
// Module      : alu_div_iter
// Description : Restoring divider, one quotient bit per enabled cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_div_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_en,
    input  logic            i_abort,
    input  logic            i_start,
    input  logic            i_signed,
    input  logic            i_rem,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    localparam int                 c_CNT_W = $clog2(XLEN) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(XLEN - 1);

    logic               r_busy;
    logic [c_CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]    r_rem;
    logic [XLEN-1:0]    r_quo;
    logic [XLEN-1:0]    r_dvs;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_sel_rem;

    logic            w_dvd_neg;
    logic            w_dvs_neg;
    logic [XLEN-1:0] w_dvd_mag;
    logic [XLEN-1:0] w_dvs_mag;
    logic [XLEN:0]   w_rem_sh;
    logic [XLEN:0]   w_diff;
    logic            w_fits;
    logic [XLEN-1:0] w_rem_nx;
    logic [XLEN-1:0] w_quo_nx;
    logic [XLEN-1:0] w_q_fix;
    logic [XLEN-1:0] w_r_fix;

    assign w_dvd_neg = i_signed & i_dividend[XLEN-1];
    assign w_dvs_neg = i_signed & i_divisor[XLEN-1];
    assign w_dvd_mag = w_dvd_neg ? -i_dividend : i_dividend;
    assign w_dvs_mag = w_dvs_neg ? -i_divisor  : i_divisor;

    // Partial remainder never exceeds the divisor, so XLEN+1 bits suffice.
    assign w_rem_sh = {r_rem, r_quo[XLEN-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_dvs};
    assign w_fits   = ~w_diff[XLEN];
    assign w_rem_nx = w_fits ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
    assign w_quo_nx = {r_quo[XLEN-2:0], w_fits};

    assign w_q_fix  = r_neg_q ? -w_quo_nx : w_quo_nx;
    assign w_r_fix  = r_neg_r ? -w_rem_nx : w_rem_nx;

    assign o_done   = r_busy & (r_cnt == c_LAST);
    assign o_result = r_sel_rem ? w_r_fix : w_q_fix;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy    <= 1'b0;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_dvs     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_sel_rem <= 1'b0;
        end else if (i_abort) begin
            r_busy <= 1'b0;
        end else if (i_en) begin
            if (i_start) begin
                r_busy    <= 1'b1;
                r_cnt     <= '0;
                r_rem     <= '0;
                r_quo     <= w_dvd_mag;
                r_dvs     <= w_dvs_mag;
                r_neg_q   <= w_dvd_neg ^ w_dvs_neg;
                r_neg_r   <= w_dvd_neg;
                r_sel_rem <= i_rem;
            end else if (r_busy) begin
                r_rem <= w_rem_nx;
                r_quo <= w_quo_nx;
                r_cnt <= r_cnt + c_CNT_W'(1);
                if (o_done) begin
                    r_busy <= 1'b0;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_md_unit.sv
// ============================================================================
// Module      : alu_md_unit
// Description : RV32IM execution unit feeding the CDB with registered results.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_md_unit
    import alu_md_unit_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRY_W = 4,
    parameter int OP_W    = 6
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               flush,
    input  logic               issue_valid,
    output logic               issue_ready,
    input  logic [OP_W-1:0]    issue_op,
    input  logic [XLEN-1:0]    issue_vj,
    input  logic [XLEN-1:0]    issue_vk,
    input  logic [XLEN-1:0]    issue_imm,
    input  logic [XLEN-1:0]    issue_pc,
    input  logic [ENTRY_W-1:0] issue_entry,
    output logic               out_valid,
    output logic [XLEN-1:0]    out_result,
    output logic [XLEN-1:0]    out_pc,
    output logic [ENTRY_W-1:0] out_entry
);

    localparam int              c_SH_W        = $clog2(XLEN);
    localparam logic [0:0]      c_ST_IDLE     = 1'b0;
    localparam logic [0:0]      c_ST_DIV_BUSY = 1'b1;
    localparam logic [XLEN-1:0] c_MIN_INT     = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] c_JALR_MASK   = {{(XLEN-1){1'b1}}, 1'b0};

    logic [0:0]         r_state;
    logic               r_valid;
    logic [XLEN-1:0]    r_result;
    logic [XLEN-1:0]    r_pc;
    logic [ENTRY_W-1:0] r_entry;
    logic [XLEN-1:0]    r_div_pc;
    logic [ENTRY_W-1:0] r_div_entry;

    op_t               w_op;
    logic              w_op_hi_zero;
    logic              w_hs;
    logic              w_use_imm;
    logic [XLEN-1:0]   w_b;
    logic [c_SH_W-1:0] w_shamt;
    logic              w_lt;
    logic              w_ltu;
    logic [XLEN-1:0]   w_pc4;
    logic [XLEN-1:0]   w_pc_imm;
    logic [XLEN-1:0]   w_jalr;
    logic              w_mul_a_s;
    logic              w_mul_b_s;
    logic [2*XLEN-1:0] w_prod;
    logic              w_is_div;
    logic              w_div_signed;
    logic              w_div_rem;
    logic              w_div_zero;
    logic              w_div_ovf;
    logic              w_div_start;
    logic              w_div_done;
    logic [XLEN-1:0]   w_div_result;
    logic [XLEN-1:0]   w_result;
    logic [XLEN-1:0]   w_next_pc;
    logic              w_taken;
    logic              w_known;

    assign w_op         = issue_op[c_OP_CODE_W-1:0];
    assign w_op_hi_zero = ((issue_op >> c_OP_CODE_W) == '0);
    assign issue_ready  = rdy_in & ~rst_in & (r_state == c_ST_IDLE);
    assign w_hs         = issue_valid & issue_ready;

    assign w_use_imm = (w_op >= c_OP_ADDI) && (w_op <= c_OP_SRAI);
    assign w_b       = w_use_imm ? issue_imm : issue_vk;
    assign w_shamt   = w_b[c_SH_W-1:0];
    assign w_lt      = $signed(issue_vj) < $signed(w_b);
    assign w_ltu     = issue_vj < w_b;
    assign w_pc4     = issue_pc + XLEN'(4);
    assign w_pc_imm  = issue_pc + issue_imm;
    assign w_jalr    = issue_vj + issue_imm;

    // Sign-extend both factors to 2*XLEN so one multiplier serves all MUL* ops.
    assign w_mul_a_s = (w_op == c_OP_MULH) || (w_op == c_OP_MULHSU);
    assign w_mul_b_s = (w_op == c_OP_MULH);
    assign w_prod    = {{XLEN{w_mul_a_s & issue_vj[XLEN-1]}}, issue_vj} *
                       {{XLEN{w_mul_b_s & issue_vk[XLEN-1]}}, issue_vk};

    assign w_is_div     = w_op_hi_zero & is_div(w_op);
    assign w_div_signed = (w_op == c_OP_DIV) || (w_op == c_OP_REM);
    assign w_div_rem    = (w_op == c_OP_REM) || (w_op == c_OP_REMU);
    assign w_div_zero   = (issue_vk == '0);
    assign w_div_ovf    = w_div_signed && (issue_vj == c_MIN_INT) && (issue_vk == '1);
    assign w_div_start  = w_hs & w_is_div & ~w_div_zero & ~w_div_ovf & ~flush;

    always_comb begin
        w_result  = '0;
        w_next_pc = w_pc4;
        w_taken   = 1'b0;
        w_known   = w_op_hi_zero;
        case (w_op)
            c_OP_ADD, c_OP_ADDI:   w_result = issue_vj + w_b;
            c_OP_SUB:              w_result = issue_vj - w_b;
            c_OP_SLL, c_OP_SLLI:   w_result = issue_vj << w_shamt;
            c_OP_SLT, c_OP_SLTI:   w_result = {{(XLEN-1){1'b0}}, w_lt};
            c_OP_SLTU, c_OP_SLTIU: w_result = {{(XLEN-1){1'b0}}, w_ltu};
            c_OP_XOR, c_OP_XORI:   w_result = issue_vj ^ w_b;
            c_OP_SRL, c_OP_SRLI:   w_result = issue_vj >> w_shamt;
            c_OP_SRA, c_OP_SRAI:   w_result = $signed(issue_vj) >>> w_shamt;
            c_OP_OR, c_OP_ORI:     w_result = issue_vj | w_b;
            c_OP_AND, c_OP_ANDI:   w_result = issue_vj & w_b;
            c_OP_LUI:              w_result = issue_imm;
            c_OP_AUIPC:            w_result = w_pc_imm;
            c_OP_JAL: begin
                w_result  = w_pc4;
                w_next_pc = w_pc_imm;
            end
            c_OP_JALR: begin
                w_result  = w_pc4;
                w_next_pc = w_jalr & c_JALR_MASK;
            end
            c_OP_BEQ, c_OP_BNE, c_OP_BLT, c_OP_BGE, c_OP_BLTU, c_OP_BGEU: begin
                case (w_op)
                    c_OP_BEQ:  w_taken = (issue_vj == issue_vk);
                    c_OP_BNE:  w_taken = (issue_vj != issue_vk);
                    c_OP_BLT:  w_taken = w_lt;
                    c_OP_BGE:  w_taken = ~w_lt;
                    c_OP_BLTU: w_taken = w_ltu;
                    default:   w_taken = ~w_ltu;
                endcase
                w_result  = {{(XLEN-1){1'b0}}, w_taken};
                w_next_pc = w_taken ? w_pc_imm : w_pc4;
            end
            c_OP_MUL:                           w_result = w_prod[XLEN-1:0];
            c_OP_MULH, c_OP_MULHSU, c_OP_MULHU: w_result = w_prod[2*XLEN-1:XLEN];
            // Only the zero-divisor and overflow shortcuts reach the CDB from here.
            c_OP_DIV, c_OP_DIVU:   w_result = w_div_zero ? '1 : issue_vj;
            c_OP_REM, c_OP_REMU:   w_result = w_div_zero ? issue_vj : '0;
            default:               w_known  = 1'b0;
        endcase
        if (!w_op_hi_zero) begin
            w_result  = '0;
            w_next_pc = w_pc4;
        end
    end

    alu_div_iter #(
        .XLEN (XLEN)
    ) u_div (
        .clk        (clk_in),
        .rst        (rst_in),
        .i_en       (rdy_in),
        .i_abort    (flush),
        .i_start    (w_div_start),
        .i_signed   (w_div_signed),
        .i_rem      (w_div_rem),
        .i_dividend (issue_vj),
        .i_divisor  (issue_vk),
        .o_done     (w_div_done),
        .o_result   (w_div_result)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state     <= c_ST_IDLE;
            r_valid     <= 1'b0;
            r_result    <= '0;
            r_pc        <= '0;
            r_entry     <= '0;
            r_div_pc    <= '0;
            r_div_entry <= '0;
        end else if (flush) begin
            r_state <= c_ST_IDLE;
            r_valid <= 1'b0;
        end else if (rdy_in) begin
            r_valid <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_div_start) begin
                        r_state     <= c_ST_DIV_BUSY;
                        r_div_pc    <= w_pc4;
                        r_div_entry <= issue_entry;
                    end else if (w_hs) begin
                        r_valid  <= 1'b1;
                        r_result <= w_result;
                        r_pc     <= w_next_pc;
                        r_entry  <= issue_entry;
                    end
                end
                default: begin
                    if (w_div_done) begin
                        r_state  <= c_ST_IDLE;
                        r_valid  <= 1'b1;
                        r_result <= w_div_result;
                        r_pc     <= r_div_pc;
                        r_entry  <= r_div_entry;
                    end
                end
            endcase
        end
    end

    // A pending pulse survives a stall and shows once the core is enabled again.
    assign out_valid  = r_valid & rdy_in;
    assign out_result = r_result;
    assign out_pc     = r_pc;
    assign out_entry  = r_entry;

`ifndef SYNTHESIS
    always_ff @(posedge clk_in) begin
        if (!rst_in && !flush && w_hs && !w_known) begin
            $warning("alu_md_unit: unknown opcode %0d, broadcasting zero", issue_op);
        end
    end
`endif

endmodule

`default_nettype wire
